// File: rtl/sw_seq_feeder.sv
// sw_seq_feeder: holds T/S/param images, streams T to the core,
// then runs NQ queries while serving S chunks on request.
module sw_seq_feeder #(
  parameter int T_W     = 18,
  parameter int T_DEPTH = 1024,
  parameter int S_W     = 128,
  parameter int CHARS   = 64,
  parameter int S_DEPTH = 256,
  parameter int NQ      = 2,
  parameter int P_W     = 16,
  parameter int R_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_wr_en,
  input  logic [1:0]                i_wr_sel,
  input  logic [15:0]               i_wr_addr,
  input  logic [S_W-1:0]            i_wr_data,
  input  logic [$clog2(T_DEPTH):0]  i_t_len,
  input  logic [15:0]               i_s_total,
  input  logic                      i_go,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err,
  output logic                      o_set_t,
  output logic                      o_start,
  output logic [P_W-1:0]            o_param,
  input  logic                      i_core_busy,
  input  logic                      i_core_valid,
  input  logic [R_W-1:0]            i_core_result,
  output logic [T_W-1:0]            o_t,
  input  logic                      i_request_s,
  output logic [S_W-1:0]            o_s,
  output logic [$clog2(CHARS):0]    o_s_valid,
  output logic                      o_res_valid,
  output logic [$clog2(NQ):0]       o_res_idx,
  output logic [R_W-1:0]            o_res
);

  localparam int TA  = $clog2(T_DEPTH);
  localparam int SA  = $clog2(S_DEPTH);
  localparam int PA  = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int CW  = $clog2(CHARS) + 1;
  localparam int QW  = $clog2(NQ) + 1;
  localparam int TLW = TA + 1;
  localparam logic [15:0] CH16 = 16'(CHARS);

  typedef enum logic [2:0] {
    IDLE, SETT, TSTREAM, QSTART, QRUN, DONE
  } state_t;

  state_t           state_q;
  logic [QW-1:0]    q_q;
  logic [TLW-1:0]   t_idx_q;
  logic [SA-1:0]    s_addr_q;
  logic [15:0]      s_rem_q;
  logic             got_q;
  logic             ph_q;

  logic [T_W-1:0]   t_mem [T_DEPTH];
  logic [S_W-1:0]   s_mem [S_DEPTH];
  logic [P_W-1:0]   p_mem [NQ];

  logic             wr_ok;
  logic [TA-1:0]    t_wa;
  logic [SA-1:0]    s_wa;
  logic [PA-1:0]    p_wa;
  logic             unused_wr;

  assign wr_ok     = i_wr_en && (state_q == IDLE);
  assign t_wa      = i_wr_addr[TA-1:0];
  assign s_wa      = i_wr_addr[SA-1:0];
  assign p_wa      = i_wr_addr[PA-1:0];
  assign unused_wr = ^i_wr_addr;

  // Images are deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_ok && i_wr_sel == 2'd0 && 32'(t_wa) < T_DEPTH)
      t_mem[t_wa] <= i_wr_data[T_W-1:0];
    if (wr_ok && i_wr_sel == 2'd1 && 32'(s_wa) < S_DEPTH)
      s_mem[s_wa] <= i_wr_data;
    if (wr_ok && i_wr_sel == 2'd2 && 32'(p_wa) < NQ)
      p_mem[p_wa] <= i_wr_data[P_W-1:0];
  end

  logic [T_W-1:0] t_rd;
  logic [S_W-1:0] s_rd;
  logic           last_q;
  logic           enter_qs;
  logic [QW-1:0]  q_nx;

  assign t_rd   = t_mem[t_idx_q[TA-1:0]];
  assign s_rd   = s_mem[s_addr_q];
  assign last_q = (q_q == QW'(NQ - 1));

  always_comb begin
    enter_qs = 1'b0;
    q_nx     = '0;
    unique case (state_q)
      TSTREAM: enter_qs = (t_idx_q >= i_t_len) && !i_core_busy;
      QRUN: begin
        enter_qs = got_q && !i_core_busy && !last_q;
        q_nx     = q_q + QW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      t_idx_q     <= '0;
      s_addr_q    <= '0;
      s_rem_q     <= '0;
      got_q       <= 1'b0;
      ph_q        <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_set_t     <= 1'b0;
      o_start     <= 1'b0;
      o_param     <= '0;
      o_t         <= '0;
      o_s         <= '0;
      o_s_valid   <= '0;
      o_res_valid <= 1'b0;
      o_res_idx   <= '0;
      o_res       <= '0;
    end else begin
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_set_t     <= 1'b0;
      o_start     <= 1'b0;
      o_res_valid <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (i_go) begin
            if (i_t_len != '0 && i_s_total != '0) begin
              state_q <= SETT;
              o_busy  <= 1'b1;
              o_set_t <= 1'b1;
              t_idx_q <= '0;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        SETT, TSTREAM: begin
          state_q <= TSTREAM;
          if (t_idx_q < i_t_len) begin
            o_t     <= t_rd;
            t_idx_q <= t_idx_q + TLW'(1);
          end else begin
            o_t <= '0;
          end
        end
        QSTART: begin
          if (!ph_q) begin
            o_start <= 1'b1;
            ph_q    <= 1'b1;
          end else begin
            state_q <= QRUN;
          end
        end
        QRUN: begin
          if (i_core_valid && !got_q) begin
            got_q       <= 1'b1;
            o_res_valid <= 1'b1;
            o_res_idx   <= q_q;
            o_res       <= i_core_result;
          end
          if (got_q && !i_core_busy && last_q) begin
            state_q <= DONE;
            o_done  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          o_busy  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase

      // A chunk is visible for one cycle; the next cycle is always a gap.
      if (o_s_valid != '0) begin
        o_s       <= '0;
        o_s_valid <= '0;
      end else if (i_request_s &&
                   (state_q == QSTART || state_q == QRUN)) begin
        o_s <= s_rd;
        if (s_rem_q <= CH16) begin
          o_s_valid <= s_rem_q[CW-1:0];
          s_addr_q  <= '0;
          s_rem_q   <= i_s_total;
        end else begin
          o_s_valid <= CW'(CHARS);
          s_addr_q  <= (s_addr_q == SA'(S_DEPTH - 1)) ?
                       '0 : s_addr_q + SA'(1);
          s_rem_q   <= s_rem_q - CH16;
        end
      end

      if (enter_qs) begin
        state_q  <= QSTART;
        q_q      <= q_nx;
        o_param  <= p_mem[q_nx[PA-1:0]];
        ph_q     <= 1'b0;
        got_q    <= 1'b0;
        s_addr_q <= '0;
        s_rem_q  <= i_s_total;
      end
    end
  end

endmodule

// File: tb/tb_sw_seq_feeder.sv
// tb_sw_seq_feeder: per-cycle vector table for a full two-query run,
// plus hand sequences for reject, held request, busy loads and reset.
module tb_sw_seq_feeder;

  localparam int T_W = 18;
  localparam int S_W = 128;
  localparam int P_W = 16;
  localparam int R_W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_wr_en;
  logic [1:0]     i_wr_sel;
  logic [15:0]    i_wr_addr;
  logic [S_W-1:0] i_wr_data;
  logic [10:0]    i_t_len;
  logic [15:0]    i_s_total;
  logic           i_go;
  logic           o_busy, o_done, o_err, o_set_t, o_start;
  logic [P_W-1:0] o_param;
  logic           i_core_busy, i_core_valid;
  logic [R_W-1:0] i_core_result;
  logic [T_W-1:0] o_t;
  logic           i_request_s;
  logic [S_W-1:0] o_s;
  logic [6:0]     o_s_valid;
  logic           o_res_valid;
  logic [1:0]     o_res_idx;
  logic [R_W-1:0] o_res;

  sw_seq_feeder dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_t_len(i_t_len), .i_s_total(i_s_total), .i_go(i_go),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_set_t(o_set_t), .o_start(o_start), .o_param(o_param),
    .i_core_busy(i_core_busy), .i_core_valid(i_core_valid),
    .i_core_result(i_core_result), .o_t(o_t),
    .i_request_s(i_request_s), .o_s(o_s), .o_s_valid(o_s_valid),
    .o_res_valid(o_res_valid), .o_res_idx(o_res_idx), .o_res(o_res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic go, req, cb, cv;
    int   cres;
    logic busy, sett, start;
    int   tsel, par, sv, ssel;
    logic rv;
    int   ridx, res;
    logic done, err;
  } vec_t;

  vec_t           tbl[$];
  int             n_vec = 0;
  int             n_bad = 0;
  logic [T_W-1:0] t_img [6];
  logic [S_W-1:0] s_img [3];
  logic [P_W-1:0] p_img [2];

  function automatic void add(
    logic go, logic req, logic cb, logic cv, int cres,
    logic busy, logic sett, logic start, int tsel, int par,
    int sv, int ssel, logic rv, int ridx, int res,
    logic done, logic err);
    vec_t v;
    v.go = go; v.req = req; v.cb = cb; v.cv = cv; v.cres = cres;
    v.busy = busy; v.sett = sett; v.start = start;
    v.tsel = tsel; v.par = par; v.sv = sv; v.ssel = ssel;
    v.rv = rv; v.ridx = ridx; v.res = res;
    v.done = done; v.err = err;
    tbl.push_back(v);
  endfunction

  function automatic logic [255:0] all_outs();
    return 256'({o_busy, o_done, o_err, o_set_t, o_start, o_param,
                 o_t, o_s, o_s_valid, o_res_valid, o_res_idx, o_res});
  endfunction

  task automatic chk(input string name, input logic [255:0] got,
                     input logic [255:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input int addr,
                    input logic [S_W-1:0] d);
    i_wr_en = 1'b1; i_wr_sel = sel;
    i_wr_addr = 16'(addr); i_wr_data = d;
    @(posedge clk); #1;
    i_wr_en = 1'b0;
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      logic [T_W-1:0] et;
      logic [S_W-1:0] es;
      logic           bad;
      i_go = tbl[i].go; i_request_s = tbl[i].req;
      i_core_busy = tbl[i].cb; i_core_valid = tbl[i].cv;
      i_core_result = R_W'(tbl[i].cres);
      @(posedge clk); #1;
      et = (tbl[i].tsel < 0) ? '0 : t_img[tbl[i].tsel];
      es = (tbl[i].ssel < 0) ? '0 : s_img[tbl[i].ssel];
      bad = (o_busy !== tbl[i].busy) || (o_set_t !== tbl[i].sett) ||
            (o_start !== tbl[i].start) || (o_t !== et) ||
            (o_s_valid !== 7'(tbl[i].sv)) || (o_s !== es) ||
            (o_res_valid !== tbl[i].rv) || (o_done !== tbl[i].done) ||
            (o_err !== tbl[i].err);
      if (tbl[i].par >= 0 && o_param !== p_img[tbl[i].par]) bad = 1'b1;
      if (tbl[i].rv && (o_res_idx !== 2'(tbl[i].ridx) ||
                        o_res !== R_W'(tbl[i].res))) bad = 1'b1;
      n_vec++;
      if (bad) begin
        n_bad++;
        $display("FAIL %s row %0d: got busy=%b sett=%b start=%b t=%h par=%h sv=%0d s=%h rv=%b idx=%0d res=%0d done=%b err=%b; want busy=%b sett=%b start=%b t=%h par#%0d sv=%0d s=%h rv=%b idx=%0d res=%0d done=%b err=%b",
                 tag, i, o_busy, o_set_t, o_start, o_t, o_param,
                 o_s_valid, o_s, o_res_valid, o_res_idx, o_res, o_done,
                 o_err, tbl[i].busy, tbl[i].sett, tbl[i].start, et,
                 tbl[i].par, tbl[i].sv, es, tbl[i].rv, tbl[i].ridx,
                 tbl[i].res, tbl[i].done, tbl[i].err);
      end
    end
    i_go = 0; i_request_s = 0; i_core_busy = 0; i_core_valid = 0;
  endtask

  initial begin
    int   cnt;
    logic found;

    i_wr_en = 0; i_wr_sel = 0; i_wr_addr = 0; i_wr_data = '0;
    i_t_len = 11'd5; i_s_total = 16'd150; i_go = 0;
    i_core_busy = 0; i_core_valid = 0; i_core_result = '0;
    i_request_s = 0;
    for (int i = 0; i < 6; i++) t_img[i] = T_W'(32'h20005 + 37 * i);
    for (int k = 0; k < 3; k++) s_img[k] = {4{32'h5A5A0000 + 32'(k)}};
    p_img[0] = 16'h1234;
    p_img[1] = 16'hBEEF;

    // r0..r23: one full run, two queries, S wrap at 150 chars
    add(1,0,0,0,0,  1,1,0,-1,-1,  0,-1, 0,-1,0,  0,0);
    add(0,0,1,0,0,  1,0,0, 0,-1,  0,-1, 0,-1,0,  0,0);
    add(0,0,1,0,0,  1,0,0, 1,-1,  0,-1, 0,-1,0,  0,0);
    add(0,1,1,0,0,  1,0,0, 2,-1,  0,-1, 0,-1,0,  0,0);
    add(0,0,1,0,0,  1,0,0, 3,-1,  0,-1, 0,-1,0,  0,0);
    add(0,0,1,0,0,  1,0,0, 4,-1,  0,-1, 0,-1,0,  0,0);
    add(0,0,1,0,0,  1,0,0,-1,-1,  0,-1, 0,-1,0,  0,0);
    add(0,0,0,0,0,  1,0,0,-1, 0,  0,-1, 0,-1,0,  0,0);
    add(0,1,0,0,0,  1,0,1,-1, 0, 64, 0, 0,-1,0,  0,0);
    add(0,1,0,0,0,  1,0,0,-1, 0,  0,-1, 0,-1,0,  0,0);
    add(0,1,0,0,0,  1,0,0,-1, 0, 64, 1, 0,-1,0,  0,0);
    add(0,0,0,0,0,  1,0,0,-1, 0,  0,-1, 0,-1,0,  0,0);
    add(0,1,0,0,0,  1,0,0,-1, 0, 22, 2, 0,-1,0,  0,0);
    add(0,0,0,0,0,  1,0,0,-1, 0,  0,-1, 0,-1,0,  0,0);
    add(0,1,0,0,0,  1,0,0,-1, 0, 64, 0, 0,-1,0,  0,0);
    add(0,0,1,1,37, 1,0,0,-1, 0,  0,-1, 1, 0,37, 0,0);
    add(0,0,1,1,99, 1,0,0,-1, 0,  0,-1, 0,-1,0,  0,0);
    add(0,0,0,0,0,  1,0,0,-1, 1,  0,-1, 0,-1,0,  0,0);
    add(0,0,0,0,0,  1,0,1,-1, 1,  0,-1, 0,-1,0,  0,0);
    add(0,1,0,0,0,  1,0,0,-1, 1, 64, 0, 0,-1,0,  0,0);
    add(0,0,0,1,12, 1,0,0,-1, 1,  0,-1, 1, 1,12, 0,0);
    add(0,0,0,0,0,  1,0,0,-1,-1,  0,-1, 0,-1,0,  1,0);
    add(0,0,0,0,0,  0,0,0,-1,-1,  0,-1, 0,-1,0,  0,0);
    add(0,1,0,0,0,  0,0,0,-1,-1,  0,-1, 0,-1,0,  0,0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), '0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) wr(2'd0, i, S_W'(t_img[i]));
    for (int k = 0; k < 3; k++) wr(2'd1, k, s_img[k]);
    for (int j = 0; j < 2; j++) wr(2'd2, j, S_W'(p_img[j]));

    i_s_total = 16'd0; i_go = 1'b1;
    @(posedge clk); #1;
    i_go = 1'b0;
    chk("err_s_total0", 256'({o_err, o_busy, o_set_t}), 256'(3'b100));
    @(posedge clk); #1;
    chk("err_one_cycle", 256'({o_err, o_busy, o_set_t}), 256'(3'b000));
    i_s_total = 16'd150; i_t_len = 11'd0; i_go = 1'b1;
    @(posedge clk); #1;
    i_go = 1'b0;
    chk("err_t_len0", 256'({o_err, o_busy, o_set_t}), 256'(3'b100));
    i_t_len = 11'd5;
    @(posedge clk); #1;

    run_table("pass1");

    i_go = 1'b1;
    @(posedge clk); #1;
    i_go = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (o_start) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("start_within_budget", 256'(found), 256'(1));
    @(posedge clk); #1;
    i_request_s = 1'b1;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (o_s_valid != 7'd0) cnt++;
    end
    i_request_s = 1'b0;
    chk("held_req_count", 256'(cnt), 256'(2));
    chk("held_req_chunk2", 256'({o_s_valid, o_s}),
        256'({7'd64, s_img[1]}));

    wr(2'd0, 0, S_W'(18'h3FFFF));
    wr(2'd1, 0, {S_W{1'b1}});
    wr(2'd2, 0, S_W'(16'hDEAD));
    chk("busy_in_qrun", 256'(o_busy), 256'(1));

    #2 rst_n = 1'b0;
    #2;
    chk("midrun_reset_outputs", all_outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", all_outs(), '0);

    run_table("pass2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sw_seq_feeder.md
SW_SEQ_FEEDER -- requirements
Module: sw_seq_feeder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- T_W, 18, width of one T word.
- T_DEPTH, 1024, number of T words held.
- S_W, 128, width of one S chunk.
- CHARS, 64, S characters per chunk.
- S_DEPTH, 256, number of S chunks held.
- NQ, 2, number of parameter sets (queries) run per go.
- P_W, 16, parameter word width.
- R_W, 16, result width.
REQ-002 Ports (name direction width meaning), one per line, clock and reset first:
- clk in 1: clock, rising edge.
- rst_n in 1: reset, asynchronous, active-low.
- i_wr_en in 1: load strobe.
- i_wr_sel in 2: load target; 0=T, 1=S, 2=param, 3=ignored.
- i_wr_addr in 16: load address, truncated to the target depth.
- i_wr_data in S_W: load data; T and param targets take the LSBs.
- i_t_len in clog2(T_DEPTH)+1: number of T words to stream.
- i_s_total in 16: total number of S characters.
- i_go in 1: start a run.
- o_busy out 1: run in progress.
- o_done out 1: one-cycle pulse when the run ends.
- o_err out 1: one-cycle pulse when a go is rejected.
- o_set_t out 1: set_t pulse to the core.
- o_start out 1: start pulse to the core.
- o_param out P_W: active parameter set.
- i_core_busy in 1: core busy.
- i_core_valid in 1: core result valid.
- i_core_result in R_W: core result.
- o_t out T_W: T word to the core.
- i_request_s in 1: core S request.
- o_s out S_W: S chunk to the core.
- o_s_valid out clog2(CHARS)+1: count of valid characters in o_s; 0 means no chunk.
- o_res_valid out 1: result pulse.
- o_res_idx out clog2(NQ)+1: query index of the result.
- o_res out R_W: captured result.

Function
REQ-003 All outputs SHALL be registered; T, S and param storage SHALL be register arrays read combinationally into the output registers.
REQ-004 Loads SHALL be accepted only in IDLE; a load while o_busy=1 SHALL be dropped without side effect.
REQ-005 FSM states SHALL be IDLE, SETT, TSTREAM, QSTART, QRUN, DONE.
REQ-006 IDLE -> SETT on i_go when i_t_len!=0 and i_s_total!=0; otherwise o_err SHALL pulse for one cycle and the FSM SHALL stay in IDLE.
REQ-007 i_go outside IDLE SHALL be ignored.
REQ-008 SETT SHALL last one cycle with o_set_t=1, then go to TSTREAM.
REQ-009 TSTREAM SHALL drive T[0..i_t_len-1] on o_t on consecutive cycles starting the cycle after SETT, then drive 0.
REQ-010 TSTREAM SHALL exit to QSTART when all words are sent and i_core_busy=0 on the same cycle; the query index q SHALL then be 0.
REQ-011 QSTART SHALL drive o_param=param[q] from entry and pulse o_start for one cycle on its second cycle, then go to QRUN.
REQ-012 In QRUN, i_core_valid SHALL produce, next cycle, o_res_valid=1, o_res_idx=q, o_res=i_core_result.
REQ-013 QRUN SHALL exit only after a result is captured and i_core_busy=0.
REQ-014 On QRUN exit, if q<NQ-1 the FSM SHALL set q=q+1 and go to QSTART; else it SHALL go to DONE.
REQ-015 DONE SHALL pulse o_done for one cycle and return to IDLE.
REQ-016 A second i_core_valid within one QRUN SHALL be ignored.
REQ-017 S server: active in QSTART and QRUN; it SHALL keep s_addr and s_rem, both reset to 0 and i_s_total at each QSTART entry.
REQ-018 On i_request_s=1 with o_s_valid==0, the next cycle SHALL drive o_s=S[s_addr] and o_s_valid=min(s_rem,CHARS).
REQ-019 After a chunk with s_rem<=CHARS, s_addr SHALL wrap to 0 and s_rem SHALL reload i_s_total; otherwise s_addr SHALL increment and s_rem SHALL decrease by CHARS.
REQ-020 o_s_valid SHALL drop to 0 and o_s to 0 the cycle after any nonzero value; requests while o_s_valid!=0 SHALL be ignored.
REQ-021 Requests outside QSTART and QRUN SHALL be ignored.
REQ-022 s_addr SHALL wrap to 0 at S_DEPTH regardless of s_rem.
REQ-023 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 rst_n low SHALL, at any time including mid-run, force IDLE, clear q, s_addr and s_rem, and zero every output.
REQ-025 rst_n SHALL NOT clear the T, S and param arrays.
REQ-026 Logic SHALL resume on the first clk edge after rst_n deasserts.

Verification
REQ-027 Load 5 T words; i_t_len=5; i_go -> o_set_t pulse, then o_t = T[0..4] on 5 consecutive cycles, then 0.
REQ-028 i_s_total=150, CHARS=64; three requests -> o_s_valid 64, 64, 22; a fourth request -> S[0] with o_s_valid 64 (wrap).
REQ-029 NQ=2, core returns 37 then 12 -> o_res_idx/o_res 0/37 then 1/12, then one o_done pulse and o_busy=0.
REQ-030 i_s_total=0 with i_go -> o_err pulse, o_busy stays 0; a load during QRUN -> the arrays are unchanged.
REQ-031 Request held high for 3 cycles -> exactly 2 chunks are delivered (alternate cycles); rst_n pulsed in QRUN -> all outputs 0 and IDLE, and a rerun gives the same results.
